// File: rtl/apb_global_pkg.sv
// Shared APB definitions: bus widths, slave memory size and the FSM / transfer / response enums.
package apb_global_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int DATA_WIDTH        = 32;
    localparam int SLAVE_MEMORY_SIZE = 12;  // KB of slave storage

    typedef enum logic [2:0] {
        NO_STATE   = 3'd0,
        IDLE       = 3'd1,
        SETUP      = 3'd2,
        ACCESS     = 3'd3,
        WAIT_STATE = 3'd4
    } apb_fsm_state_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } tx_type_e;

    typedef enum logic {
        SLV_OKAY  = 1'b0,
        SLV_ERROR = 1'b1
    } slave_error_e;

endpackage

// File: rtl/apb_slave_mem.sv
// Word-organised slave storage with byte-enabled synchronous write and combinational read.
module apb_slave_mem #(
    parameter int  DATA_WIDTH = 32,
    parameter int  MEM_DEPTH  = 3072,
    localparam int STRB_W     = DATA_WIDTH / 8,
    localparam int ADDR_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  pclk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  in_range;

    assign in_range = ({1'b0, addr} < DEPTH_LIM);
    assign rdata    = in_range ? mem[addr] : '0;

    // NOTE: storage has no reset branch; clearing every word would add a reset fan-out to the whole array.
    always_ff @(posedge pclk) begin
        if (we && in_range) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/apb_slave_responder.sv
// APB slave responder: setup/access FSM, address decode and programmable wait states over apb_slave_mem.
// Define APB_SLAVE_PROT_CHECK_EN to answer non-secure (pprot[1]=1) transfers with pslverr.
module apb_slave_responder
    import apb_global_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
    parameter int                       DATA_WIDTH    = apb_global_pkg::DATA_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = '0,
    parameter int                       MEM_DEPTH     = SLAVE_MEMORY_SIZE * 1024 / (DATA_WIDTH / 8)
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [ADDRESS_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0]    pwdata,
    input  logic [DATA_WIDTH/8-1:0]  pstrb,
    input  logic [2:0]               pprot,
    input  logic [3:0]               cfg_wait_states,
    output logic                     pready,
    output logic [DATA_WIDTH-1:0]    prdata,
    output logic                     pslverr
);

    localparam int STRB_W     = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(STRB_W);
    localparam int MEM_AW     = $clog2(MEM_DEPTH);

    apb_fsm_state_e           state;
    slave_error_e             err_q;
    tx_type_e                 tx_type;
    logic [3:0]               wait_cnt;
    logic [ADDRESS_WIDTH-1:0] offset;
    logic [ADDRESS_WIDTH-1:0] word_idx;
    logic                     addr_err;
    logic                     prot_err;
    logic                     setup_err;
    logic                     busy;
    logic                     mem_we;
    logic                     unused_prot;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    assign tx_type = pwrite ? WRITE : READ;

    // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
    always_comb begin
        offset    = '0;
        word_idx  = '0;
        addr_err  = 1'b0;
        offset    = paddr - MIN_ADDRESS;
        word_idx  = offset >> BYTE_SHIFT;
        addr_err  = (paddr < MIN_ADDRESS)
                 || (word_idx >= ADDRESS_WIDTH'(MEM_DEPTH))
                 || (paddr[BYTE_SHIFT-1:0] != '0);
        setup_err = addr_err || prot_err;
    end

`ifdef APB_SLAVE_PROT_CHECK_EN
    assign prot_err    = pprot[1];
    assign unused_prot = pprot[0] ^ pprot[2];
`else
    assign prot_err    = 1'b0;
    assign unused_prot = ^pprot;
`endif

    // Address phase is held stable by the master, so the live bus drives the write at completion.
    assign busy   = (state == SETUP) || (state == WAIT_STATE);
    assign mem_we = busy && psel && penable && pready && (tx_type == WRITE) && (err_q == SLV_OKAY);

    apb_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .pclk  (pclk),
        .we    (mem_we),
        .addr  (word_idx[MEM_AW-1:0]),
        .wdata (pwdata),
        .wstrb (pstrb),
        .rdata (mem_rdata)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= IDLE;
            err_q    <= SLV_OKAY;
            wait_cnt <= '0;
            pready   <= 1'b0;
            prdata   <= '0;
            pslverr  <= 1'b0;
        end else begin
            case (state)
                SETUP, WAIT_STATE: begin
                    if (!psel) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                        pready   <= 1'b0;
                        prdata   <= '0;
                        pslverr  <= 1'b0;
                    end else if (pready) begin
                        if (penable) begin
                            state   <= ACCESS;
                            pready  <= 1'b0;
                            prdata  <= '0;
                            pslverr <= 1'b0;
                        end
                    end else begin
                        state    <= WAIT_STATE;
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            pready  <= 1'b1;
                            pslverr <= (err_q == SLV_ERROR);
                        end
                    end
                end
                // IDLE, a completed ACCESS and the unused NO_STATE all look for a new SETUP
                default: begin
                    if (psel && !penable) begin
                        state    <= SETUP;
                        wait_cnt <= cfg_wait_states;
                        err_q    <= setup_err ? SLV_ERROR : SLV_OKAY;
                        prdata   <= ((tx_type == READ) && !setup_err) ? mem_rdata : '0;
                        pready   <= (cfg_wait_states == 4'd0);
                        pslverr  <= (cfg_wait_states == 4'd0) && setup_err;
                    end else begin
                        state   <= IDLE;
                        pready  <= 1'b0;
                        pslverr <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave_responder.sv
// Randomised self-checking bench for apb_slave_responder against a transaction-level memory model.
module tb_apb_slave_responder;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 3072;
    localparam logic [31:0] MIN_A = 32'h0000_0000;
`ifdef APB_SLAVE_PROT_CHECK_EN
    localparam bit PROT_CHK = 1'b1;
`else
    localparam bit PROT_CHK = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          preset;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [3:0]    cfg_wait_states;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    always #5 pclk = ~pclk;

    apb_slave_responder #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .MIN_ADDRESS   (MIN_A),
        .MEM_DEPTH     (DEPTH)
    ) dut (
        .pclk            (pclk),
        .preset          (preset),
        .psel            (psel),
        .penable         (penable),
        .pwrite          (pwrite),
        .paddr           (paddr),
        .pwdata          (pwdata),
        .pstrb           (pstrb),
        .pprot           (pprot),
        .cfg_wait_states (cfg_wait_states),
        .pready          (pready),
        .prdata          (prdata),
        .pslverr         (pslverr)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: word-addressed memory holding only words the bench has written.
    logic [31:0] model_mem [int];

    function automatic bit model_err(input logic [31:0] a, input logic [2:0] prot);
        bit e;
        e = (a < MIN_A) || ((a % 4) != 0) || (((a - MIN_A) / 4) >= DEPTH);
        if (PROT_CHK && prot[1]) e = 1'b1;
        return e;
    endfunction

    // Expectations published by the driver for the cycle in progress.
    bit          chk_on = 1'b0;
    logic        exp_pready, exp_pslverr;
    logic [31:0] exp_prdata;
    bit          exp_rd_known;

    always @(negedge pclk) begin
        if (chk_on) begin
            check("pready", pready, exp_pready);
            check("pslverr", pslverr, exp_pslverr);
            if (exp_pready && exp_rd_known) check("prdata", prdata, exp_prdata);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
            psel = 1'b0; penable = 1'b0;
            exp_pready = 1'b0; exp_pslverr = 1'b0;
        end
    endtask

    // One APB transfer; abort_at / rst_at select an access cycle to drop psel or pulse preset (-1 = never).
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input int abort_at, input int rst_at,
                        output logic [31:0] rd, output logic err_o, output int lowc);
        bit          e;
        bit          known;
        int          idx;
        logic [31:0] exp_rd;
        logic [31:0] tmp;
        e      = model_err(addr, prot);
        idx    = int'((addr - MIN_A) / 4);
        known  = wr || e;
        exp_rd = '0;
        if (!wr && !e && model_mem.exists(idx)) begin
            if (!$isunknown(model_mem[idx])) begin
                known  = 1'b1;
                exp_rd = model_mem[idx];
            end
        end
        rd = '0; err_o = 1'b0; lowc = 0;

        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        pstrb = strb; pprot = prot; cfg_wait_states = 4'(waits);
        exp_pready = 1'b0; exp_pslverr = 1'b0;

        for (int k = 0; k <= waits; k++) begin
            @(posedge pclk); #1;
            penable      = 1'b1;
            exp_pready   = (k == waits);
            exp_pslverr  = (k == waits) && e;
            exp_prdata   = exp_rd;
            exp_rd_known = known;
            if (k == abort_at) begin
                psel = 1'b0; penable = 1'b0;
                @(posedge pclk); #1;
                exp_pready = 1'b0; exp_pslverr = 1'b0;
                return;
            end
            if (k == rst_at) begin
                psel = 1'b0; penable = 1'b0;
                #2 preset = 1'b1;
                exp_pready = 1'b0; exp_pslverr = 1'b0;
                #1;
                check("rst_pready", pready, 0);
                check("rst_prdata", prdata, 0);
                check("rst_pslverr", pslverr, 0);
                @(posedge pclk); #1;
                preset = 1'b0;
                return;
            end
            @(negedge pclk);
            if (pready !== 1'b1) lowc++;
            if (k == waits) begin
                rd    = prdata;
                err_o = pslverr;
            end
        end

        if (wr && !e) begin
            tmp = model_mem.exists(idx) ? model_mem[idx] : 'x;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) tmp[b*8 +: 8] = data[b*8 +: 8];
            end
            model_mem[idx] = tmp;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lc;
        logic [31:0] addr;
        int          r, waits, abort_at;

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; cfg_wait_states = '0;
        exp_pready = 1'b0; exp_pslverr = 1'b0; exp_prdata = '0; exp_rd_known = 1'b0;

        repeat (3) @(posedge pclk);
        #1;
        check("reset_pready", pready, 0);
        check("reset_prdata", prdata, 0);
        check("reset_pslverr", pslverr, 0);
        preset = 1'b0;
        chk_on = 1'b1;

        // Zero-wait write/read round trip, then a single-byte strobe merge
        xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, -1, -1, rd, er, lc);
        check("w10_err", er, 0);
        check("w10_low_cycles", lc, 0);
        xfer(0, 32'h10, 32'h0, 4'h0, 3'b000, 0, -1, -1, rd, er, lc);
        check("r10_data", rd, 32'hDEADBEEF);
        xfer(1, 32'h10, 32'h0000_00AA, 4'b0001, 3'b000, 0, -1, -1, rd, er, lc);
        xfer(0, 32'h10, 32'h0, 4'h0, 3'b000, 0, -1, -1, rd, er, lc);
        check("r10_strb_data", rd, 32'hDEADBEAA);

        // Three wait states on a read
        xfer(1, 32'h20, 32'h1234_5678, 4'hF, 3'b000, 0, -1, -1, rd, er, lc);
        xfer(0, 32'h20, 32'h0, 4'h0, 3'b000, 3, -1, -1, rd, er, lc);
        check("r20_low_cycles", lc, 3);
        check("r20_data", rd, 32'h1234_5678);

        // Out-of-range and misaligned writes error and leave memory alone; pstrb=0 is a no-op
        xfer(1, DEPTH * 4, 32'hFFFF_FFFF, 4'hF, 3'b000, 0, -1, -1, rd, er, lc);
        check("w_oor_err", er, 1);
        xfer(1, 32'h13, 32'hFFFF_FFFF, 4'hF, 3'b000, 1, -1, -1, rd, er, lc);
        check("w_misalign_err", er, 1);
        xfer(1, 32'h10, 32'h5555_5555, 4'h0, 3'b000, 0, -1, -1, rd, er, lc);
        check("w_nostrb_err", er, 0);
        xfer(0, 32'h10, 32'h0, 4'h0, 3'b000, 0, -1, -1, rd, er, lc);
        check("r10_after_err", rd, 32'hDEADBEAA);

        // Reset in the second of five wait states, on a read and then on a write
        xfer(0, 32'h10, 32'h0, 4'h0, 3'b000, 5, -1, 1, rd, er, lc);
        xfer(1, 32'h10, 32'h1111_1111, 4'hF, 3'b000, 5, -1, 1, rd, er, lc);
        idle(1);
        // penable without a preceding SETUP must be ignored
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10;
            exp_pready = 1'b0; exp_pslverr = 1'b0;
        end
        idle(1);
        xfer(0, 32'h10, 32'h0, 4'h0, 3'b000, 0, -1, -1, rd, er, lc);
        check("r10_after_reset", rd, 32'hDEADBEAA);

        // Non-secure access
        xfer(1, 32'h40, 32'h0102_0304, 4'hF, 3'b000, 0, -1, -1, rd, er, lc);
        xfer(1, 32'h40, 32'hCAFE_F00D, 4'hF, 3'b010, 0, -1, -1, rd, er, lc);
        check("w_prot_err", er, PROT_CHK ? 1 : 0);
        xfer(0, 32'h40, 32'h0, 4'h0, 3'b000, 0, -1, -1, rd, er, lc);
        check("r40_prot_data", rd, PROT_CHK ? 32'h0102_0304 : 32'hCAFE_F00D);

        // Seed a known region plus the last word, then randomised traffic
        for (int i = 0; i < 64; i++) begin
            xfer(1, 4 * i, $urandom, 4'hF, 3'b000, 0, -1, -1, rd, er, lc);
        end
        xfer(1, (DEPTH - 1) * 4, 32'hA5A5_0F0F, 4'hF, 3'b000, 0, -1, -1, rd, er, lc);
        xfer(0, (DEPTH - 1) * 4, 32'h0, 4'h0, 3'b000, 1, -1, -1, rd, er, lc);
        check("r_top_word", rd, 32'hA5A5_0F0F);

        repeat (250) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       addr = 4 * $urandom_range(0, 63);
            else if (r == 6) addr = 4 * $urandom_range(0, 63) + $urandom_range(1, 3);
            else if (r == 7) addr = (DEPTH - 1) * 4;
            else if (r == 8) addr = DEPTH * 4 + 4 * $urandom_range(0, 15);
            else             addr = 32'hFFFF_FFF0;
            waits    = int'($urandom_range(0, 4));
            abort_at = -1;
            if (waits > 0 && $urandom_range(0, 9) == 0) abort_at = int'($urandom_range(0, waits - 1));
            xfer($urandom_range(0, 1) == 1, addr, $urandom, 4'($urandom), 3'($urandom),
                 waits, abort_at, -1, rd, er, lc);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        idle(2);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_responder.md
APB_SLAVE_RESPONDER -- requirements
Module: apb_slave_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: paddr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: pwdata/prdata width; pstrb width is DATA_WIDTH/8.
REQ-003 SHALL have parameter MIN_ADDRESS, default 32'h0000_0000: lowest byte address decoded.
REQ-004 SHALL have parameter MEM_DEPTH, default 3072: words of storage (SLAVE_MEMORY_SIZE KB / (DATA_WIDTH/8)).
REQ-005 SHALL have port pclk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port preset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have ports psel, penable, pwrite, all input, 1 bit each: APB select, enable and direction (1=WRITE, 0=READ).
REQ-008 SHALL have ports paddr (input, ADDRESS_WIDTH), pwdata (input, DATA_WIDTH), pstrb (input, DATA_WIDTH/8), pprot (input, 3).
REQ-009 SHALL have port cfg_wait_states, input, 4: wait states for the next transfer, sampled in SETUP.
REQ-010 SHALL have ports pready (output, 1), prdata (output, DATA_WIDTH) and pslverr (output, 1), all registered.

Function
REQ-011 SHALL run an FSM over apb_fsm_state_e: IDLE, SETUP, ACCESS, WAIT_STATE; NO_STATE is unused and decodes to IDLE.
REQ-012 SHALL enter SETUP in the cycle that psel=1 and penable=0 are sampled, from IDLE or from a completed ACCESS (back-to-back).
REQ-013 SHALL, at the SETUP edge, latch cfg_wait_states into a down-counter, compute the error flag, load prdata (reads) and set pready=1 when cfg_wait_states=0, else 0.
REQ-014 SHALL hold WAIT_STATE with pready=0, decrementing the counter each cycle, and raise pready in the cycle after the counter reaches 1; total pready-low access cycles equal cfg_wait_states.
REQ-015 SHALL complete a transfer on the edge that samples psel=1, penable=1 and pready=1; pready SHALL return to 0 on the following cycle.
REQ-016 SHALL compute the word index as (paddr - MIN_ADDRESS) >> log2(DATA_WIDTH/8).
REQ-017 SHALL flag an error when paddr < MIN_ADDRESS, the index is >= MEM_DEPTH, or paddr is not aligned to DATA_WIDTH/8.
REQ-018 SHALL, on a completed write without error, update only the bytes whose pstrb bit is 1; pstrb=0 leaves memory unchanged and is not an error.
REQ-019 SHALL drive prdata with the addressed word on reads without error, and with 0 on errored reads and on all writes.
REQ-020 SHALL drive pslverr equal to the error flag only while pready=1; otherwise 0; an errored write SHALL NOT modify memory.
REQ-021 SHALL abort to IDLE with no memory update when psel drops before completion.
REQ-022 SHALL ignore penable=1 when no SETUP preceded it, holding IDLE with pready=0.

Reset
REQ-023 SHALL, while preset=1, force IDLE, counter 0, pready=0, prdata=0 and pslverr=0, and SHALL discard any in-flight transfer.
REQ-024 SHALL leave memory contents unreset; the first transfer after release SHALL need a fresh SETUP.

Configuration
REQ-025 SHALL, with APB_SLAVE_PROT_CHECK_EN defined, treat pprot[1]=1 (non-secure) as an error under REQ-017/REQ-020; without the macro, pprot SHALL be ignored.

Structure
REQ-026 SHALL import apb_fsm_state_e, tx_type_e, slave_error_e, ADDRESS_WIDTH, DATA_WIDTH and SLAVE_MEMORY_SIZE from apb_global_pkg; no new package types are needed.
REQ-027 SHALL place storage in one sub-module apb_slave_mem (byte-enabled write, combinational read); the FSM, decode and wait counter stay in the top.

Verification
REQ-028 Write 0xDEADBEEF to 0x10, pstrb=4'hF, 0 waits -> pready=1 in the first ACCESS cycle, pslverr=0; read of 0x10 -> prdata=0xDEADBEEF.
REQ-029 Write 0x000000AA to 0x10, pstrb=4'b0001 -> read returns 0xDEADBEAA.
REQ-030 Read of 0x20 with cfg_wait_states=3 -> exactly 3 ACCESS cycles with pready=0, then pready=1 with the correct prdata.
REQ-031 Write to MIN_ADDRESS+MEM_DEPTH*4 and to 0x13 -> pslverr=1 with pready=1; memory is unchanged.
REQ-032 Assert preset during the 2nd of 5 wait states -> outputs are 0 immediately and no write occurs; the next transfer needs a SETUP.
REQ-033 With APB_SLAVE_PROT_CHECK_EN defined, write with pprot=3'b010 -> pslverr=1 and memory unchanged; without the macro -> pslverr=0 and the write is applied.
